// File: rtl/fork_join_alu.sv
// fork_join_alu: chunked vector ALU that forks L lanes per cycle and joins results into a V-element register.
// Ports: CLK/RST (sync, active-high); OpType, ALUControl select mode and op;
// RD1_VEC_i/RD2_VEC_i/Scalar_i feed the lanes; Vec_A_o/Vec_B_o show current lane operands;
// counter is the chunk index; AluResult_V_o/valid_o are the joined vector and its done pulse;
// AluResult_S_o/ALUFlags are the scalar ALU, present only with FORK_JOIN_SCALAR_ALU_EN defined.
module fork_join_alu #(
    parameter int N = 32,
    parameter int V = 20,
    parameter int L = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [1:0]            OpType,
    input  logic [1:0]            ALUControl,
    input  logic [V-1:0][N-1:0]   RD1_VEC_i,
    input  logic [V-1:0][N-1:0]   RD2_VEC_i,
    input  logic [N-1:0]          Scalar_i,
    input  logic [N-1:0]          RD1_S_i,
    input  logic [N-1:0]          RD2_S_i,
    output logic [L-1:0][N-1:0]   Vec_A_o,
    output logic [L-1:0][N-1:0]   Vec_B_o,
    output logic [2:0]            counter,
    output logic [V-1:0][N-1:0]   AluResult_V_o,
    output logic                  valid_o,
    output logic [N-1:0]          AluResult_S_o,
    output logic [1:0]            ALUFlags
);
    localparam int C = V / L;

    function automatic logic [N-1:0] alu(input logic [N-1:0] a, input logic [N-1:0] b, input logic [1:0] op);
        return op == 2'b00 ? a + b : op == 2'b01 ? a - b : op == 2'b10 ? a & b : a | b;
    endfunction

    logic [2:0]          counter_q, counter_d;
    logic [V-1:0][N-1:0] res_q, res_d;
    logic                valid_q, valid_d;

    // Chunk select is unrolled over constant indices so every element select is static.
    always_comb begin
        Vec_A_o = '0;
        Vec_B_o = '0;
        for (int c = 0; c < C; c++)
            for (int k = 0; k < L; k++)
                if (counter_q == 3'(c) && OpType != 2'b00) begin
                    Vec_A_o[k] = RD1_VEC_i[c*L+k];
                    Vec_B_o[k] = OpType == 2'b10 ? Scalar_i : RD2_VEC_i[c*L+k];
                end
    end

    always_comb begin
        res_d = res_q;
        for (int c = 0; c < C; c++)
            for (int k = 0; k < L; k++)
                if (counter_q == 3'(c) && OpType != 2'b00)
                    res_d[c*L+k] = alu(Vec_A_o[k], Vec_B_o[k], ALUControl);
        counter_d = counter_q == 3'(C-1) ? 3'd0 : counter_q + 3'd1;
        valid_d   = counter_q == 3'(C-1) && OpType != 2'b00;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            counter_q <= '0;
            res_q     <= '0;
            valid_q   <= 1'b0;
        end else begin
            counter_q <= counter_d;
            res_q     <= res_d;
            valid_q   <= valid_d;
        end
    end

    assign counter       = counter_q;
    assign AluResult_V_o = res_q;
    assign valid_o       = valid_q;

`ifdef FORK_JOIN_SCALAR_ALU_EN
    assign AluResult_S_o = alu(RD1_S_i, RD2_S_i, ALUControl);
    assign ALUFlags      = {AluResult_S_o[N-1], AluResult_S_o == '0};
`else
    logic unused_s;
    assign unused_s      = ^{RD1_S_i, RD2_S_i};
    assign AluResult_S_o = '0;
    assign ALUFlags      = '0;
`endif
endmodule

// File: tb/tb_fork_join_alu.sv
// tb_fork_join_alu: random and directed checks of fork_join_alu against a behavioural chunk model.
module tb_fork_join_alu;
    localparam int N = 32;
    localparam int V = 20;
    localparam int L = 4;
    localparam int C = V / L;

    logic                clk = 1'b0;
    logic                rst;
    logic [1:0]          op, ctrl;
    logic [V-1:0][N-1:0] rd1, rd2, res_v;
    logic [N-1:0]        sc, s1, s2, res_s;
    logic [L-1:0][N-1:0] va, vb;
    logic [2:0]          cnt;
    logic                vld;
    logic [1:0]          flg;

    int total = 0;
    int bad = 0;
    bit checking = 1'b0;

    logic [N-1:0] exp_res [V];
    int           exp_cnt = 0;
    bit           exp_valid = 1'b0;

    always #5 clk = ~clk;

    fork_join_alu #(.N(N), .V(V), .L(L)) dut (
        .CLK(clk), .RST(rst), .OpType(op), .ALUControl(ctrl),
        .RD1_VEC_i(rd1), .RD2_VEC_i(rd2), .Scalar_i(sc),
        .RD1_S_i(s1), .RD2_S_i(s2),
        .Vec_A_o(va), .Vec_B_o(vb), .counter(cnt),
        .AluResult_V_o(res_v), .valid_o(vld),
        .AluResult_S_o(res_s), .ALUFlags(flg)
    );

    function automatic logic [N-1:0] f(input logic [N-1:0] a, input logic [N-1:0] b, input logic [1:0] c);
        case (c)
            2'b00:   return a + b;
            2'b01:   return a - b;
            2'b10:   return a & b;
            default: return a | b;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [V*N-1:0] act, input logic [V*N-1:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, want);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    function automatic logic [V-1:0][N-1:0] vec_of(input int mul, input int add);
        logic [V-1:0][N-1:0] e;
        for (int i = 0; i < V; i++) e[i] = N'(mul * i + add);
        return e;
    endfunction

    // Model: a chunk counter walking 0..C-1, each non-scalar edge overwrites that chunk's L elements.
    always @(posedge clk) begin
        if (rst) begin
            exp_cnt   <= 0;
            exp_valid <= 1'b0;
            for (int i = 0; i < V; i++) exp_res[i] <= '0;
        end else begin
            exp_valid <= op != 2'b00 && exp_cnt == C - 1;
            if (op != 2'b00)
                for (int k = 0; k < L; k++)
                    exp_res[exp_cnt*L+k] <= f(rd1[exp_cnt*L+k], op == 2'b10 ? sc : rd2[exp_cnt*L+k], ctrl);
            exp_cnt <= (exp_cnt + 1) % C;
        end
    end

    always @(negedge clk) begin
        logic [V-1:0][N-1:0] ev;
        logic [L-1:0][N-1:0] ea, eb;
        logic [N-1:0]        es;
        logic [1:0]          ef;
        if (checking) begin
            for (int i = 0; i < V; i++) ev[i] = exp_res[i];
            for (int k = 0; k < L; k++) begin
                ea[k] = op == 2'b00 ? '0 : rd1[exp_cnt*L+k];
                eb[k] = op == 2'b00 ? '0 : op == 2'b10 ? sc : rd2[exp_cnt*L+k];
            end
`ifdef FORK_JOIN_SCALAR_ALU_EN
            es = f(s1, s2, ctrl);
            ef = {es[N-1], es == '0};
`else
            es = '0;
            ef = '0;
`endif
            chk("m_counter", cnt, exp_cnt[2:0]);
            chk("m_valid", vld, exp_valid);
            chk("m_result", res_v, ev);
            chk("m_vec_a", va, ea);
            chk("m_vec_b", vb, eb);
            chk("m_scalar", res_s, es);
            chk("m_flags", flg, ef);
        end
    end

    initial begin
        rst = 1'b1; op = 2'b00; ctrl = 2'b00;
        rd1 = '0; rd2 = '0; sc = '0; s1 = '0; s2 = '0;
        step(2);
        checking = 1'b1;
        @(negedge clk);
        chk("rst_counter", cnt, 0);
        chk("rst_valid", vld, 0);
        chk("rst_result", res_v, 0);

        // vector-vector ADD from chunk 0
        @(posedge clk); #2;
        rst = 1'b0; rd1 = vec_of(1, 0); rd2 = vec_of(2, 0); op = 2'b01; ctrl = 2'b00;
        step(5);
        @(negedge clk);
        chk("vv_add", res_v, vec_of(3, 0));
        chk("vv_valid", vld, 1);
        chk("vv_counter", cnt, 0);
        step(1);
        @(negedge clk);
        chk("valid_once", vld, 0);

        // vector-scalar ADD with broadcast 3
        @(posedge clk); #2;
        op = 2'b10; sc = 32'd3;
        step(5);
        @(negedge clk);
        chk("vs_add", res_v, vec_of(1, 3));
        chk("vs_lane_b", vb, {L{32'd3}});

        // vector-vector SUB negative results
        @(posedge clk); #2;
        op = 2'b01; ctrl = 2'b01;
        step(5);
        @(negedge clk);
        chk("sub_e1", res_v[1], 32'hFFFF_FFFF);
        chk("sub_e19", res_v[19], 32'hFFFF_FFED);

        // modular wrap of ADD
        @(posedge clk); #2;
        ctrl = 2'b00; rd1 = {V{32'hFFFF_FFFF}}; rd2 = {V{32'd1}};
        step(5);
        @(negedge clk);
        chk("add_wrap", res_v, 0);

        // reset in mid-sweep at chunk 2, then a clean sweep
        @(posedge clk); #2;
        rd1 = vec_of(1, 0); rd2 = vec_of(2, 0);
        for (int t = 0; t < 10 && cnt != 3'd2; t++) step(1);
        chk("wait_cnt2", cnt, 2);
        rst = 1'b1;
        step(1);
        @(negedge clk);
        chk("mid_rst_counter", cnt, 0);
        chk("mid_rst_result", res_v, 0);
        chk("mid_rst_valid", vld, 0);
        @(posedge clk); #2;
        rst = 1'b0;
        step(5);
        @(negedge clk);
        chk("post_rst_sweep", res_v, vec_of(3, 0));
        chk("post_rst_valid", vld, 1);

        // scalar mode holds the vector register
        @(posedge clk); #2;
        op = 2'b00;
        for (int t = 0; t < 5; t++) begin
            step(1);
            @(negedge clk);
            chk("scalar_mode_valid", vld, 0);
        end
        chk("scalar_mode_hold", res_v, vec_of(3, 0));

        // scalar ALU
        @(posedge clk); #2;
        s1 = 32'd5; s2 = 32'd5; ctrl = 2'b01;
        @(negedge clk);
`ifdef FORK_JOIN_SCALAR_ALU_EN
        chk("s_zero_res", res_s, 0);
        chk("s_zero_flags", flg, 2'b01);
`else
        chk("s_off_res", res_s, 0);
        chk("s_off_flags", flg, 0);
`endif
        @(posedge clk); #2;
        s1 = 32'd2;
        @(negedge clk);
`ifdef FORK_JOIN_SCALAR_ALU_EN
        chk("s_neg_res", res_s, 32'hFFFF_FFFD);
        chk("s_neg_flags", flg, 2'b10);
`else
        chk("s_off_res2", res_s, 0);
        chk("s_off_flags2", flg, 0);
`endif

        // random traffic, including mode changes mid-sweep and occasional reset
        for (int t = 0; t < 400; t++) begin
            @(posedge clk); #2;
            rst  = ($urandom % 32) == 0;
            op   = 2'($urandom);
            ctrl = 2'($urandom);
            sc   = $urandom;
            s1   = ($urandom % 8 == 0) ? s2 : $urandom;
            s2   = $urandom;
            if ($urandom % 4 == 0)
                for (int i = 0; i < V; i++) begin
                    rd1[i] = $urandom;
                    rd2[i] = $urandom;
                end
        end
        step(1);
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
